// File: rtl/instr_fetch_unit.sv
// ============================================================================
// Module   : instr_fetch_unit
// Purpose  : PC owner and instruction fetcher for KGP_RISC (req/ack to imem,
//            valid/ready to datapath). Optional halt state via IFU_HALT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_INC   = 32'd4
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instruction,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        flush,
  input  logic [31:0] flush_target,
  output logic [31:0] pc,
`ifdef IFU_HALT_EN
  input  logic        halt,
  output logic        halted,
`endif
  output logic [31:0] next_pc
);

  localparam logic [1:0]  S_IDLE     = 2'd0;
  localparam logic [1:0]  S_REQ      = 2'd1;
  localparam logic [1:0]  S_VALID    = 2'd2;
`ifdef IFU_HALT_EN
  localparam logic [1:0]  S_HALT     = 2'd3;
`endif
  localparam logic [31:0] C_ALIGN    = 32'hFFFF_FFFC;
  localparam logic [31:0] C_RESET_PC = RESET_PC & C_ALIGN;

  logic [1:0]  r_state;
  logic [31:0] r_pc;
  logic [31:0] r_instr;
  logic [31:0] r_saved;
  logic        r_drop;

  logic [31:0] w_pc_inc;
  logic [31:0] w_flush_tgt;
  logic [31:0] w_branch_tgt;

  assign w_pc_inc     = r_pc + PC_INC;
  assign w_flush_tgt  = flush_target & C_ALIGN;
  assign w_branch_tgt = branch_target & C_ALIGN;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_pc    <= C_RESET_PC;
      r_instr <= 32'd0;
      r_saved <= 32'd0;
      r_drop  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (flush) begin
            r_pc <= w_flush_tgt;
          end
          r_state <= S_REQ;
        end
        S_REQ: begin
          // The address must stay put while a request is outstanding, so a
          // flush without ack is remembered and applied when the ack arrives.
          if (imem_ack) begin
            if (flush) begin
              r_pc   <= w_flush_tgt;
              r_drop <= 1'b0;
            end else if (r_drop) begin
              r_pc   <= r_saved;
              r_drop <= 1'b0;
            end else begin
              r_instr <= imem_rdata;
              r_state <= S_VALID;
            end
          end else if (flush) begin
            r_drop  <= 1'b1;
            r_saved <= w_flush_tgt;
          end
        end
        S_VALID: begin
          if (flush) begin
            r_pc    <= w_flush_tgt;
            r_state <= S_REQ;
          end else if (instr_ready) begin
`ifdef IFU_HALT_EN
            if (halt) begin
              r_pc    <= w_pc_inc;
              r_state <= S_HALT;
            end else begin
              r_pc    <= branch_taken ? w_branch_tgt : w_pc_inc;
              r_state <= S_REQ;
            end
`else
            r_pc    <= branch_taken ? w_branch_tgt : w_pc_inc;
            r_state <= S_REQ;
`endif
          end
        end
`ifdef IFU_HALT_EN
        S_HALT: begin
          r_state <= S_HALT;
        end
`endif
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign imem_req    = (r_state == S_REQ);
  assign imem_addr   = r_pc;
  assign instruction = r_instr;
  assign instr_valid = (r_state == S_VALID);
  assign pc          = r_pc;
  assign next_pc     = w_pc_inc;
`ifdef IFU_HALT_EN
  assign halted      = (r_state == S_HALT);
`endif

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
// ============================================================================
// Module   : tb_instr_fetch_unit
// Purpose  : Scoreboard bench for instr_fetch_unit (halt checks under IFU_HALT_EN).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_instr_fetch_unit;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instruction;
  logic        instr_valid;
  logic        instr_ready;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        flush;
  logic [31:0] flush_target;
  logic [31:0] pc;
  logic [31:0] next_pc;
`ifdef IFU_HALT_EN
  logic        halt;
  logic        halted;
`endif

  int   n_cmp;
  int   n_err;
  int   ack_delay;
  int   wait_cnt;
  exp_t        exp_q[$];
  logic [31:0] exp_fetch[$];

  logic        prev_req;
  logic        prev_ack;
  logic [31:0] prev_addr;

  instr_fetch_unit #(
    .RESET_PC (32'h0000_0000),
    .PC_INC   (32'd4)
  ) u_dut (
    .clk           (clk),
    .rst           (rst),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .instruction   (instruction),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .flush         (flush),
    .flush_target  (flush_target),
    .pc            (pc),
`ifdef IFU_HALT_EN
    .halt          (halt),
    .halted        (halted),
`endif
    .next_pc       (next_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a == 32'h0000_000C) ? 32'hDEAD_BEEF : (a ^ 32'h5A5A_A5A5);
  endfunction

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic push_fetch(input logic [31:0] a, input logic expect_instr);
    exp_t e;
    exp_fetch.push_back(a);
    if (expect_instr) begin
      e.pc   = a;
      e.data = mem_word(a);
      exp_q.push_back(e);
    end
  endtask

  // Instruction memory: acks ack_delay cycles after the request is first seen.
  initial begin
    imem_ack   = 1'b0;
    imem_rdata = 32'd0;
    wait_cnt   = 0;
    forever begin
      @(posedge clk);
      #1;
      imem_ack = 1'b0;
      if (imem_req) begin
        wait_cnt++;
        if (wait_cnt >= ack_delay) begin
          imem_ack   = 1'b1;
          imem_rdata = mem_word(imem_addr);
          wait_cnt   = 0;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  // Fetch-address scoreboard and request-address stability monitor.
  initial begin
    prev_req  = 1'b0;
    prev_ack  = 1'b0;
    prev_addr = 32'd0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        prev_req = 1'b0;
        prev_ack = 1'b0;
      end else begin
        if (imem_req && prev_req && !prev_ack)
          check_value("addr_stable", imem_addr, prev_addr);
        if (imem_req && imem_ack) begin
          check_value("fetch_expected", (exp_fetch.size() != 0) ? 32'd1 : 32'd0, 32'd1);
          if (exp_fetch.size() != 0)
            check_value("fetch_addr", imem_addr, exp_fetch.pop_front());
        end
        prev_req  = imem_req;
        prev_ack  = imem_ack;
        prev_addr = imem_addr;
      end
    end
  end

  task automatic consume(input int hold, input logic do_ready, input logic br,
                         input logic [31:0] btgt, input logic do_flush,
                         input logic [31:0] ftgt, input logic hlt);
    int   w;
    exp_t e;
    w = 0;
    while (!instr_valid && w < 60) begin
      @(negedge clk);
      w++;
    end
    if (!instr_valid) begin
      check_value("valid_timeout", {31'd0, instr_valid}, 32'd1);
      return;
    end
    check_value("exp_q_nonempty", (exp_q.size() != 0) ? 32'd1 : 32'd0, 32'd1);
    if (exp_q.size() == 0) return;
    e = exp_q.pop_front();
    check_value("pc", pc, e.pc);
    check_value("instruction", instruction, e.data);
    check_value("next_pc", next_pc, e.pc + 32'd4);
    for (int i = 0; i < hold; i++) begin
      branch_taken  = 1'b1;
      branch_target = 32'h0000_0500;
      @(negedge clk);
      check_value("hold_instr", instruction, e.data);
      check_value("hold_pc", pc, e.pc);
      check_value("hold_req", {31'd0, imem_req}, 32'd0);
      check_value("hold_valid", {31'd0, instr_valid}, 32'd1);
    end
    instr_ready   = do_ready;
    branch_taken  = br;
    branch_target = btgt;
    flush         = do_flush;
    flush_target  = ftgt;
`ifdef IFU_HALT_EN
    halt          = hlt;
`else
    if (hlt) check_value("halt_unsupported", 32'd1, 32'd0);
`endif
    if (do_ready || do_flush) begin
      @(negedge clk);
    end
    instr_ready  = 1'b0;
    branch_taken = 1'b0;
    flush        = 1'b0;
`ifdef IFU_HALT_EN
    halt         = 1'b0;
`endif
  endtask

  task automatic check_reset_state();
    check_value("rst_valid", {31'd0, instr_valid}, 32'd0);
    check_value("rst_req", {31'd0, imem_req}, 32'd0);
    check_value("rst_pc", pc, 32'h0000_0000);
    check_value("rst_next_pc", next_pc, 32'h0000_0004);
    check_value("rst_instr", instruction, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    n_cmp         = 0;
    n_err         = 0;
    ack_delay     = 2;
    rst           = 1'b0;
    instr_ready   = 1'b0;
    branch_taken  = 1'b0;
    branch_target = 32'd0;
    flush         = 1'b0;
    flush_target  = 32'd0;
`ifdef IFU_HALT_EN
    halt          = 1'b0;
`endif
    repeat (3) @(negedge clk);
    check_reset_state();

    // Sequential fetch 0,4,8,C and first-valid latency.
    push_fetch(32'h0, 1'b1);
    push_fetch(32'h4, 1'b1);
    push_fetch(32'h8, 1'b1);
    push_fetch(32'hC, 1'b1);
    rst = 1'b1;
    n = 0;
    while (!instr_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    check_value("first_valid_latency", n, 32'd3);
    consume(0, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
    consume(0, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
    consume(0, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
    push_fetch(32'h10, 1'b1);
    consume(5, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);

    // Branch with unaligned target; branch without ready held beforehand.
    push_fetch(32'h100, 1'b1);
    consume(2, 1'b1, 1'b1, 32'h0000_0103, 1'b0, 32'd0, 1'b0);

    // Flush while a request is outstanding; second flush overwrites target.
    push_fetch(32'h104, 1'b0);
    push_fetch(32'h200, 1'b1);
    ack_delay = 4;
    consume(0, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
    flush = 1'b1; flush_target = 32'h300;
    @(negedge clk);
    flush_target = 32'h200;
    @(negedge clk);
    flush = 1'b0;
    for (int i = 0; i < 2; i++) begin
      check_value("drop_addr_hold", imem_addr, 32'h104);
      check_value("drop_no_valid", {31'd0, instr_valid}, 32'd0);
      @(negedge clk);
    end

    // Flush coinciding with the ack: data discarded, refetch at target.
    push_fetch(32'h204, 1'b0);
    push_fetch(32'h2F0, 1'b1);
    consume(0, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
    ack_delay = 2;
    @(negedge clk);
    flush = 1'b1; flush_target = 32'h2F1;
    @(negedge clk);
    flush = 1'b0;

    // Flush beats ready in S_VALID, then wrap past 0xFFFF_FFFC.
    push_fetch(32'hFFFF_FFFC, 1'b1);
    consume(0, 1'b1, 1'b0, 32'd0, 1'b1, 32'hFFFF_FFFC, 1'b0);
    ack_delay = 6;
    consume(0, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
    check_value("wrap_req", {31'd0, imem_req}, 32'd1);
    check_value("wrap_addr", imem_addr, 32'h0);

    // Reset mid-request, then flush while in S_IDLE.
    rst = 1'b0;
    #1;
    check_reset_state();
    @(negedge clk);
    ack_delay = 2;
    push_fetch(32'h44, 1'b1);
    rst = 1'b1; flush = 1'b1; flush_target = 32'h46;
    @(negedge clk);
    flush = 1'b0;
    push_fetch(32'h48, 1'b1);
    consume(0, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
    push_fetch(32'h20, 1'b1);
    consume(0, 1'b0, 1'b0, 32'd0, 1'b1, 32'h20, 1'b0);

`ifdef IFU_HALT_EN
    consume(0, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1);
    flush = 1'b1; flush_target = 32'h80;
    for (int i = 0; i < 6; i++) begin
      check_value("halt_halted", {31'd0, halted}, 32'd1);
      check_value("halt_req", {31'd0, imem_req}, 32'd0);
      check_value("halt_valid", {31'd0, instr_valid}, 32'd0);
      check_value("halt_pc", pc, 32'h24);
      @(negedge clk);
    end
    flush = 1'b0;
    rst = 1'b0;
    #1;
    check_value("halt_rst_halted", {31'd0, halted}, 32'd0);
    check_reset_state();
    @(negedge clk);
    push_fetch(32'h0, 1'b1);
    rst = 1'b1;
    consume(0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
`else
    push_fetch(32'h24, 1'b1);
    consume(0, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
    consume(0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
`endif

    repeat (2) @(negedge clk);
    check_value("exp_q_drained", exp_q.size(), 32'd0);
    check_value("fetch_q_drained", exp_fetch.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Producer side of the instruction interface: owns the PC, fetches words from instruction memory over a req/ack handshake, and presents each word to the datapath under valid/ready.
- Applies branch redirects when the datapath consumes an instruction, and applies asynchronous flush redirects at any point.
- Sits between instruction memory and the decode/datapath stage of KGP_RISC.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded at reset (bits [1:0] forced to 0).
- PC_INC, 4, sequential PC increment in bytes.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset (rst=0 resets immediately).
- imem_req  output  1  fetch request, held high until imem_ack.
- imem_addr  output  32  fetch address; equals pc and is stable while imem_req=1.
- imem_ack  input  1  one-cycle pulse, data valid on imem_rdata this cycle; ignored when imem_req=0.
- imem_rdata  input  32  fetched instruction word.
- instruction  output  32  registered instruction to the datapath.
- instr_valid  output  1  instruction is valid.
- instr_ready  input  1  datapath consumes the instruction this cycle.
- branch_taken  input  1  sampled only on the valid&ready handshake.
- branch_target  input  32  redirect address for branch_taken.
- flush  input  1  redirect request, any state.
- flush_target  input  32  redirect address for flush.
- pc  output  32  address of the held or in-flight instruction.
- next_pc  output  32  pc+PC_INC, the link value for the mem_to_reg path.

Behaviour:
- Reset (rst=0):
  - state=S_IDLE, pc=RESET_PC, instruction=0, drop=0.
  - Outputs: instr_valid=0, imem_req=0, next_pc=RESET_PC+4.
- FSM states: S_IDLE, S_REQ, S_VALID.
- S_IDLE: imem_req=0, instr_valid=0. Next cycle goes to S_REQ.
- S_REQ: imem_req=1, imem_addr=pc.
  - On imem_ack with drop=0: instruction<=imem_rdata, go to S_VALID.
  - On imem_ack with drop=1: discard the data, pc<=saved target, drop<=0, stay in S_REQ (the new request is issued the next cycle).
- S_VALID: instr_valid=1, imem_req=0.
  - On instr_ready: pc<=branch_taken ? branch_target : pc+PC_INC, go to S_REQ.
  - Without instr_ready: hold instruction, pc and instr_valid unchanged.
- Latency: with ack one cycle after req, the first instr_valid appears 3 cycles after reset release. Steady state is one instruction per 2 cycles plus memory wait.
- Flush handling, by state:
  - S_IDLE: pc<=flush_target, then proceed normally.
  - S_VALID: flush wins over instr_ready. The instruction is not consumed, instr_valid drops next cycle, pc<=flush_target, go to S_REQ.
  - S_REQ without ack the same cycle: request is outstanding, so imem_addr must not change. Set drop=1 and save flush_target. A later flush before the ack overwrites the saved target.
  - S_REQ with ack the same cycle: discard the data, pc<=flush_target, stay in S_REQ, drop stays 0.
- Alignment: all loaded targets have bits [1:0] forced to 0.
- Arithmetic: pc+PC_INC is modulo 2^32 (0xFFFF_FFFC -> 0x0000_0000). next_pc uses the same wrap.
- Reset mid-operation: asynchronous return to reset values. Any pending ack after reset release is ignored because imem_req=0 in S_IDLE.
- Stability: instruction changes only on an accepted (non-dropped) ack.

Optional Feature:
- Macro IFU_HALT_EN.
- When defined:
  - Adds input halt (1 bit) and output halted (1 bit), and a state S_HALT.
  - halt sampled high on the valid&ready handshake -> S_HALT.
  - In S_HALT: imem_req=0, instr_valid=0, halted=1, pc frozen at the consumed pc+PC_INC. flush is ignored. Exit only via reset.
- When undefined: no halt port, no halted port, no S_HALT; behaviour exactly as above.

Test Plan:
- Reset release with RESET_PC=0, memory acking one cycle after req -> imem_addr sequence 0x0, 0x4, 0x8; instr_valid first high 3 cycles after rst goes high; next_pc=0x4 while pc=0x0.
- instr_ready held low 5 cycles in S_VALID, memory returning 0xDEADBEEF -> instruction stays 0xDEADBEEF, imem_req stays 0, pc unchanged; on ready, next request goes to pc+4.
- Handshake with branch_taken=1, branch_target=0x103 -> next imem_addr=0x100; branch_taken=1 without instr_ready -> no effect.
- flush=1, flush_target=0x200 while a req to 0x10 is outstanding, ack 3 cycles later -> imem_addr stays 0x10 until the ack, the data is dropped (instr_valid stays 0), then a req to 0x200 is issued.
- pc=0xFFFF_FFFC consumed without branch -> next imem_addr=0x0; flush and instr_ready in the same cycle in S_VALID -> next fetch at flush_target, instruction not advanced.
- With IFU_HALT_EN: halt=1 on a handshake at pc=0x20 -> halted=1, imem_req=0 indefinitely, pc=0x24, flush ignored; rst low then high -> fetch resumes at RESET_PC.
